// File: rtl/ppi_icb_arbiter_pkg.sv
// Shared types and constants for the PPI ICB two-master arbiter.
// Holds the master ID encoding, the round-robin reset value and the FIFO pointer-width helper.
package ppi_icb_arbiter_pkg;

  localparam int   ID_W   = 1;
  localparam int   AW_DEF = 32;
  localparam int   DW_DEF = 32;

  typedef enum logic [ID_W-1:0] {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } mst_e;

  // rr_last resets to m1 so that m0 wins the first contested grant.
  localparam mst_e RR_RST = MST_M1;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ppi_icb_arbiter_if.sv
// ICB command/response bundle shared by the masters and the PPI-side port.
// With PPI_ARB_LOCK_EN defined, the command channel also carries a lock bit.
interface ppi_icb_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic            cmd_read;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;
`ifdef PPI_ARB_LOCK_EN
  logic            cmd_lock;
`endif
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_err;
  logic [DW-1:0]   rsp_rdata;

`ifdef PPI_ARB_LOCK_EN
  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_lock, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_lock, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
`else
  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
`endif

endinterface

// File: rtl/ppi_icb_arbiter_id_fifo.sv
// In-order FIFO of master IDs for commands issued but not yet answered.
// Push while full and pop while empty are ignored.
module ppi_arb_id_fifo
  import ppi_icb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  mst_e din_i,
  output mst_e dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mst_e          mem_q [2**PW];
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_d  = do_push ? next_ptr(wr_q) : wr_q;
    rd_d  = do_pop  ? next_ptr(rd_q) : rd_q;
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/ppi_icb_arbiter.sv
// Two-master round-robin ICB arbiter in front of the PPI slave port, with in-order response routing.
// Optional PPI_ARB_LOCK_EN adds per-master cmd_lock that pins the grant across a locked sequence.
module ppi_icb_arbiter
  import ppi_icb_arbiter_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int OUTS_DP = 2
) (
  input  logic               clk,
  input  logic               rst,
  ppi_icb_arbiter_if.slave   m0_icb,
  ppi_icb_arbiter_if.slave   m1_icb,
  ppi_icb_arbiter_if.master  o_icb,
  output logic               spurious_rsp
);

  mst_e          rr_last_q, rr_last_d;
  logic          hold_q, hold_d;
  mst_e          hold_mst_q, hold_mst_d;
  logic          spur_q, spur_d;
  mst_e          sel, head;
  logic          sel_valid, fifo_full, fifo_empty;
  logic          cmd_hs, rsp_pop;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
`ifdef PPI_ARB_LOCK_EN
  logic          locked_q, locked_d;
  mst_e          lock_mst_q, lock_mst_d;
  logic          sel_lock;
`endif

  // Grant priority: lock owner, then held master, then round-robin.
  always_comb begin
    if (rr_last_q == MST_M0) sel = m1_icb.cmd_valid ? MST_M1 : MST_M0;
    else                     sel = m0_icb.cmd_valid ? MST_M0 : MST_M1;
    if (hold_q) sel = hold_mst_q;
`ifdef PPI_ARB_LOCK_EN
    if (locked_q) sel = lock_mst_q;
`endif
  end

  assign sel_valid = (sel == MST_M1) ? m1_icb.cmd_valid : m0_icb.cmd_valid;
  assign sel_addr  = (sel == MST_M1) ? m1_icb.cmd_addr  : m0_icb.cmd_addr;
  assign sel_wdata = (sel == MST_M1) ? m1_icb.cmd_wdata : m0_icb.cmd_wdata;

  assign o_icb.cmd_valid = sel_valid & ~fifo_full;
  assign o_icb.cmd_addr  = sel_addr;
  assign o_icb.cmd_wdata = sel_wdata;
  assign o_icb.cmd_read  = (sel == MST_M1) ? m1_icb.cmd_read  : m0_icb.cmd_read;
  assign o_icb.cmd_wmask = (sel == MST_M1) ? m1_icb.cmd_wmask : m0_icb.cmd_wmask;
`ifdef PPI_ARB_LOCK_EN
  assign o_icb.cmd_lock  = (sel == MST_M1) ? m1_icb.cmd_lock  : m0_icb.cmd_lock;
  assign sel_lock        = o_icb.cmd_lock;
`endif

  assign m0_icb.cmd_ready = (sel == MST_M0) & o_icb.cmd_ready & ~fifo_full;
  assign m1_icb.cmd_ready = (sel == MST_M1) & o_icb.cmd_ready & ~fifo_full;
  assign cmd_hs           = o_icb.cmd_valid & o_icb.cmd_ready;

  // With nothing outstanding, ready follows valid so a stray response drains in one cycle.
  assign o_icb.rsp_ready = fifo_empty ? o_icb.rsp_valid
                                      : ((head == MST_M1) ? m1_icb.rsp_ready : m0_icb.rsp_ready);
  assign rsp_pop         = o_icb.rsp_valid & o_icb.rsp_ready & ~fifo_empty;

  assign m0_icb.rsp_valid = o_icb.rsp_valid & ~fifo_empty & (head == MST_M0);
  assign m1_icb.rsp_valid = o_icb.rsp_valid & ~fifo_empty & (head == MST_M1);
  assign m0_icb.rsp_err   = (~fifo_empty && head == MST_M0) ? o_icb.rsp_err   : 1'b0;
  assign m1_icb.rsp_err   = (~fifo_empty && head == MST_M1) ? o_icb.rsp_err   : 1'b0;
  assign m0_icb.rsp_rdata = (~fifo_empty && head == MST_M0) ? o_icb.rsp_rdata : '0;
  assign m1_icb.rsp_rdata = (~fifo_empty && head == MST_M1) ? o_icb.rsp_rdata : '0;

  assign spurious_rsp = spur_q;

  always_comb begin
    rr_last_d  = rr_last_q;
    hold_d     = hold_q;
    hold_mst_d = hold_mst_q;
    spur_d     = spur_q | (o_icb.rsp_valid & fifo_empty);
`ifdef PPI_ARB_LOCK_EN
    locked_d   = locked_q;
    lock_mst_d = lock_mst_q;
    if (cmd_hs) begin
      locked_d   = sel_lock;
      lock_mst_d = sel;
      if (!locked_q) rr_last_d = sel;
    end
`else
    if (cmd_hs) rr_last_d = sel;
`endif
    if (cmd_hs) begin
      hold_d = 1'b0;
    end else if (o_icb.cmd_valid && !o_icb.cmd_ready) begin
      hold_d     = 1'b1;
      hold_mst_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_q  <= RR_RST;
      hold_q     <= 1'b0;
      hold_mst_q <= MST_M0;
      spur_q     <= 1'b0;
`ifdef PPI_ARB_LOCK_EN
      locked_q   <= 1'b0;
      lock_mst_q <= MST_M0;
`endif
    end else begin
      rr_last_q  <= rr_last_d;
      hold_q     <= hold_d;
      hold_mst_q <= hold_mst_d;
      spur_q     <= spur_d;
`ifdef PPI_ARB_LOCK_EN
      locked_q   <= locked_d;
      lock_mst_q <= lock_mst_d;
`endif
    end
  end

  ppi_arb_id_fifo #(.DEPTH(OUTS_DP)) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_hs),
    .pop_i   (rsp_pop),
    .din_i   (sel),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_ppi_icb_arbiter.sv
// Directed bench for ppi_icb_arbiter: grants, hold, response routing, spurious drop, reset and optional lock.
module tb_ppi_icb_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic spurious_rsp;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ppi_icb_arbiter_if #(.AW(32), .DW(32)) m0_if ();
  ppi_icb_arbiter_if #(.AW(32), .DW(32)) m1_if ();
  ppi_icb_arbiter_if #(.AW(32), .DW(32)) o_if ();

  ppi_icb_arbiter #(.AW(32), .DW(32), .OUTS_DP(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0_icb       (m0_if.slave),
    .m1_icb       (m1_if.slave),
    .o_icb        (o_if.master),
    .spurious_rsp (spurious_rsp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    m0_if.cmd_valid = 0; m0_if.cmd_addr = '0; m0_if.cmd_read = 0;
    m0_if.cmd_wdata = '0; m0_if.cmd_wmask = '0; m0_if.rsp_ready = 0;
    m1_if.cmd_valid = 0; m1_if.cmd_addr = '0; m1_if.cmd_read = 0;
    m1_if.cmd_wdata = '0; m1_if.cmd_wmask = '0; m1_if.rsp_ready = 0;
`ifdef PPI_ARB_LOCK_EN
    m0_if.cmd_lock = 0; m1_if.cmd_lock = 0;
`endif
    o_if.cmd_ready = 0; o_if.rsp_valid = 0; o_if.rsp_err = 0; o_if.rsp_rdata = '0;
  endtask

  task automatic chk_quiet(input string tag);
    check({tag, " o_cmd_valid"}, o_if.cmd_valid, 0);
    check({tag, " m0_cmd_ready"}, m0_if.cmd_ready, 0);
    check({tag, " m1_cmd_ready"}, m1_if.cmd_ready, 0);
    check({tag, " m0_rsp_valid"}, m0_if.rsp_valid, 0);
    check({tag, " m1_rsp_valid"}, m1_if.rsp_valid, 0);
    check({tag, " o_rsp_ready"}, o_if.rsp_ready, 0);
    check({tag, " spurious"}, spurious_rsp, 0);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #12;
    chk_quiet("reset");
    @(negedge clk) rst = 1'b1;
    tick();

    // 1: alternating grants, stall at full, same-cycle push+pop
    m0_if.cmd_valid = 1; m0_if.cmd_addr = 32'h100; m0_if.cmd_read = 1;
    m1_if.cmd_valid = 1; m1_if.cmd_addr = 32'h200; m1_if.cmd_read = 1;
    m0_if.rsp_ready = 1; m1_if.rsp_ready = 1;
    o_if.cmd_ready = 1;
    settle();
    check("t1 g1 valid", o_if.cmd_valid, 1);
    check("t1 g1 addr", o_if.cmd_addr, 32'h100);
    check("t1 g1 m0 ready", m0_if.cmd_ready, 1);
    check("t1 g1 m1 ready", m1_if.cmd_ready, 0);
    tick();
    check("t1 g2 addr", o_if.cmd_addr, 32'h200);
    check("t1 g2 m1 ready", m1_if.cmd_ready, 1);
    check("t1 g2 m0 ready", m0_if.cmd_ready, 0);
    tick();
    check("t1 full valid", o_if.cmd_valid, 0);
    check("t1 full m0 ready", m0_if.cmd_ready, 0);
    o_if.rsp_valid = 1; o_if.rsp_rdata = 32'h11;
    settle();
    check("t1 r1 m0 valid", m0_if.rsp_valid, 1);
    check("t1 r1 m0 rdata", m0_if.rsp_rdata, 32'h11);
    check("t1 r1 m1 valid", m1_if.rsp_valid, 0);
    check("t1 r1 o ready", o_if.rsp_ready, 1);
    tick();
    o_if.rsp_rdata = 32'h22;
    settle();
    check("t1 r2 m1 valid", m1_if.rsp_valid, 1);
    check("t1 r2 m1 rdata", m1_if.rsp_rdata, 32'h22);
    check("t1 r2 m0 rdata", m0_if.rsp_rdata, 0);
    check("t1 g3 valid", o_if.cmd_valid, 1);
    check("t1 g3 addr", o_if.cmd_addr, 32'h100);
    tick();
    m0_if.cmd_valid = 0; m1_if.cmd_valid = 0; o_if.rsp_rdata = 32'h33;
    settle();
    check("t5 pushpop head", m0_if.rsp_valid, 1);
    check("t5 pushpop rdata", m0_if.rsp_rdata, 32'h33);
    tick();
    o_if.rsp_valid = 0;
    m0_if.cmd_valid = 1; m0_if.cmd_addr = 32'h300;
    settle();
    check("t5 fill1", o_if.cmd_valid, 1);
    tick();
    m0_if.cmd_valid = 0; m1_if.cmd_valid = 1; m1_if.cmd_addr = 32'h400;
    settle();
    check("t5 fill2", o_if.cmd_valid, 1);
    check("t5 fill2 addr", o_if.cmd_addr, 32'h400);
    tick();
    m0_if.cmd_valid = 1;
    settle();
    check("t5 exact full", o_if.cmd_valid, 0);
    m0_if.cmd_valid = 0; m1_if.cmd_valid = 0;
    o_if.rsp_valid = 1; o_if.rsp_rdata = 32'h44;
    settle();
    check("t1 drain m0", m0_if.rsp_valid, 1);
    tick();
    o_if.rsp_rdata = 32'h55;
    settle();
    check("t1 drain m1", m1_if.rsp_valid, 1);
    check("t1 drain m1 rdata", m1_if.rsp_rdata, 32'h55);
    tick();
    o_if.rsp_valid = 0;

    // 2: hold keeps m1 selected while the slave stalls
    m1_if.cmd_valid = 1; m1_if.cmd_addr = 32'h1001_2000; m1_if.cmd_read = 1;
    o_if.cmd_ready = 0;
    settle();
    check("t2 c1 valid", o_if.cmd_valid, 1);
    check("t2 c1 addr", o_if.cmd_addr, 32'h1001_2000);
    check("t2 c1 read", o_if.cmd_read, 1);
    check("t2 c1 m1 ready", m1_if.cmd_ready, 0);
    tick();
    m0_if.cmd_valid = 1; m0_if.cmd_addr = 32'h500; m0_if.cmd_read = 0;
    settle();
    check("t2 c2 addr", o_if.cmd_addr, 32'h1001_2000);
    check("t2 c2 m0 ready", m0_if.cmd_ready, 0);
    tick();
    check("t2 c3 addr", o_if.cmd_addr, 32'h1001_2000);
    tick();
    o_if.cmd_ready = 1;
    settle();
    check("t2 hs m1 ready", m1_if.cmd_ready, 1);
    check("t2 hs m0 ready", m0_if.cmd_ready, 0);
    tick();
    m1_if.cmd_valid = 0;
    settle();
    check("t2 next addr", o_if.cmd_addr, 32'h500);
    check("t2 next m0 ready", m0_if.cmd_ready, 1);
    tick();
    m0_if.cmd_valid = 0;
    o_if.rsp_valid = 1; o_if.rsp_rdata = 32'h66;
    settle();
    check("t2 rsp m1", m1_if.rsp_valid, 1);
    tick();
    o_if.rsp_rdata = 32'h77;
    settle();
    check("t2 rsp m0", m0_if.rsp_valid, 1);
    tick();
    o_if.rsp_valid = 0;

    // 3: write then read, in-order routing and back-pressure
    m0_if.cmd_valid = 1; m0_if.cmd_addr = 32'h600; m0_if.cmd_read = 0;
    m0_if.cmd_wdata = 32'h1234_5678; m0_if.cmd_wmask = 4'h3;
    settle();
    check("t3 w wdata", o_if.cmd_wdata, 32'h1234_5678);
    check("t3 w wmask", o_if.cmd_wmask, 4'h3);
    check("t3 w read", o_if.cmd_read, 0);
    check("t3 w ready", m0_if.cmd_ready, 1);
    tick();
    m0_if.cmd_valid = 0;
    m1_if.cmd_valid = 1; m1_if.cmd_addr = 32'h700; m1_if.cmd_read = 1;
    settle();
    check("t3 r ready", m1_if.cmd_ready, 1);
    tick();
    m1_if.cmd_valid = 0;
    o_if.rsp_valid = 1; o_if.rsp_rdata = 32'h0; o_if.rsp_err = 0;
    settle();
    check("t3 rsp1 m0", m0_if.rsp_valid, 1);
    check("t3 rsp1 m1", m1_if.rsp_valid, 0);
    tick();
    o_if.rsp_rdata = 32'hDEAD_BEEF; o_if.rsp_err = 1; m1_if.rsp_ready = 0;
    settle();
    check("t3 rsp2 m1 valid", m1_if.rsp_valid, 1);
    check("t3 rsp2 m1 rdata", m1_if.rsp_rdata, 32'hDEAD_BEEF);
    check("t3 rsp2 m1 err", m1_if.rsp_err, 1);
    check("t3 rsp2 m0 err", m0_if.rsp_err, 0);
    check("t3 rsp2 m0 rdata", m0_if.rsp_rdata, 0);
    check("t3 rsp2 o ready", o_if.rsp_ready, 0);
    tick();
    check("t3 rsp2 held", m1_if.rsp_valid, 1);
    m1_if.rsp_ready = 1;
    settle();
    check("t3 rsp2 o ready1", o_if.rsp_ready, 1);
    tick();
    o_if.rsp_valid = 0; o_if.rsp_err = 0;

    // 4: response with nothing outstanding
    o_if.rsp_valid = 1; o_if.rsp_rdata = 32'hBAD;
    settle();
    check("t4 drop ready", o_if.rsp_ready, 1);
    check("t4 m0 valid", m0_if.rsp_valid, 0);
    check("t4 m1 valid", m1_if.rsp_valid, 0);
    check("t4 pre flag", spurious_rsp, 0);
    tick();
    o_if.rsp_valid = 0;
    settle();
    check("t4 flag", spurious_rsp, 1);
    check("t4 ready idle", o_if.rsp_ready, 0);
    tick();
    check("t4 sticky", spurious_rsp, 1);

    // 5: async reset with two outstanding commands
    m0_if.cmd_valid = 1; m0_if.cmd_addr = 32'h800;
    tick();
    m0_if.cmd_valid = 0; m1_if.cmd_valid = 1; m1_if.cmd_addr = 32'h900;
    tick();
    idle();
    rst = 1'b0;
    #1;
    chk_quiet("t5 rst");
    tick();
    @(negedge clk) rst = 1'b1;
    tick();
    m0_if.rsp_ready = 1; m1_if.rsp_ready = 1;
    o_if.rsp_valid = 1; o_if.rsp_rdata = 32'h99;
    settle();
    check("t5 late m0 valid", m0_if.rsp_valid, 0);
    check("t5 late m1 valid", m1_if.rsp_valid, 0);
    check("t5 late drop", o_if.rsp_ready, 1);
    tick();
    o_if.rsp_valid = 0;
    settle();
    check("t5 late flag", spurious_rsp, 1);

`ifdef PPI_ARB_LOCK_EN
    // 6: locked sequence from m0 keeps m1 out
    o_if.cmd_ready = 1;
    m1_if.cmd_valid = 1; m1_if.cmd_addr = 32'hB00;
    m0_if.cmd_valid = 1; m0_if.cmd_addr = 32'hA00; m0_if.cmd_lock = 1;
    settle();
    check("t6 l1 m0", m0_if.cmd_ready, 1);
    tick();
    o_if.rsp_valid = 1;
    settle();
    check("t6 l2 m0", m0_if.cmd_ready, 1);
    check("t6 l2 m1", m1_if.cmd_ready, 0);
    tick();
    m0_if.cmd_lock = 0;
    settle();
    check("t6 l3 m0", m0_if.cmd_ready, 1);
    check("t6 l3 m1", m1_if.cmd_ready, 0);
    tick();
    check("t6 m1 ready", m1_if.cmd_ready, 1);
    check("t6 m0 ready", m0_if.cmd_ready, 0);
    check("t6 m1 addr", o_if.cmd_addr, 32'hB00);
    tick();
    m0_if.cmd_valid = 0; m1_if.cmd_valid = 0;
    tick();
    o_if.rsp_valid = 0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
